times_table_sweeper: RTL

Self-checking stimulus engine for the times-table multiplier block. On `start` it drives every (a, b) operand pair in order into the multiplier's `a`/`b`/`enable` inputs and captures the returned `result` after a fixed read latency. It checks each result against an internally computed product and reports a pass/fail summary. The block sits on the initiator side of the multiplier's lookup interface, so exhaustive checking runs in hardware instead of in a testbench.

---
 rtl/times_table_sweeper.sv | 115 +++++++++++
 1 files changed

// File: rtl/times_table_sweeper.sv
// Exhaustive stimulus/checker for the 3x3-bit times-table multiplier: issues all
// 64 operand pairs, compares each returned product after LATENCY cycles, reports a summary.
module times_table_sweeper #(
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [2:0] a,
  output logic [2:0] b,
  output logic       enable,
  input  logic [5:0] result,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] err_count,
  output logic [2:0] first_err_a,
  output logic [2:0] first_err_b,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t     state, state_next;
  logic [5:0] idx;
  logic [2:0] drain_cnt;

  // Delay line that runs alongside the multiplier's read path.
  logic       pipe_v [LATENCY];
  logic [2:0] pipe_a [LATENCY];
  logic [2:0] pipe_b [LATENCY];
  logic [5:0] pipe_p [LATENCY];

  logic       mismatch;
  logic [6:0] err_next;

  // All outputs come from registers; result only feeds the error registers.
  assign a         = idx[5:3];
  assign b         = idx[2:0];
  assign enable    = (state == ISSUE);
  assign busy      = (state == ISSUE) || (state == DRAIN);
  assign done      = (state == FIN);
  assign fsm_state = state;

  assign mismatch = pipe_v[LATENCY-1] && (pipe_p[LATENCY-1] != result);
  assign err_next = mismatch ? err_count + 7'd1 : err_count;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE:   if (idx == 6'd63) state_next = DRAIN;
      DRAIN:   if (drain_cnt == 3'(LATENCY - 1)) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= 6'd0;
      drain_cnt   <= 3'd0;
      err_count   <= 7'd0;
      first_err_a <= 3'd0;
      first_err_b <= 3'd0;
      pass        <= 1'b0;
      for (int i = 0; i < LATENCY; i++) pipe_v[i] <= 1'b0;
    end else begin
      state <= state_next;

      pipe_v[0] <= enable;
      pipe_a[0] <= a;
      pipe_b[0] <= b;
      pipe_p[0] <= 6'(a) * 6'(b);
      for (int i = 1; i < LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
        pipe_b[i] <= pipe_b[i-1];
        pipe_p[i] <= pipe_p[i-1];
      end

      if (mismatch) begin
        err_count <= err_next;
        if (err_count == 7'd0) begin
          first_err_a <= pipe_a[LATENCY-1];
          first_err_b <= pipe_b[LATENCY-1];
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            idx         <= 6'd0;
            err_count   <= 7'd0;
            first_err_a <= 3'd0;
            first_err_b <= 3'd0;
            pass        <= 1'b0;
          end
        end
        ISSUE: begin
          // idx parks at 63 so a/b read 7/7 while draining.
          if (idx != 6'd63) idx <= idx + 6'd1;
          drain_cnt <= 3'd0;
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 3'd1;
          if (state_next == FIN) pass <= (err_next == 7'd0);
        end
        default: ;
      endcase
    end
  end

endmodule
